leds_trace: RTL and testbench

Synthesizable change-trace buffer for the SoC LED bus. It compares a WIDTH-bit input against its previous sampled value every cycle. On each change it pushes a {value, timestamp} record into a DEPTH-entry FIFO, which firmware or a bench drains through a valid/ready port. It sits beside Soc, tapping LEDS (or any GPIO bus), and replaces print-on-change monitoring with a hardware log that survives into synthesis and FPGA debug.

---
 rtl/leds_trace_pkg.sv | 18 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/leds_trace.sv | 90 +++++++++
 tb/tb_leds_trace.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leds_trace_pkg.sv
// Shared types and default sizing for the LED change-trace buffer.
package leds_trace_pkg;

  localparam int LT_WIDTH      = 6;
  localparam int LT_DEPTH      = 16;
  localparam int LT_TS_WIDTH   = 16;
  localparam int LT_DROP_WIDTH = 8;

  localparam int PTR_W = $clog2(LT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One logged event: bus value and the timestamp of the edge that saw it.
  typedef struct packed {
    logic [LT_WIDTH-1:0]    leds;
    logic [LT_TS_WIDTH-1:0] ts;
  } record_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy counter.
// Full/empty come from the counter, so pointers can wrap freely.
module sync_fifo #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; clear wins over any push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is reset so the head output is never X, even when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/leds_trace.sv
// Change-trace buffer: logs {value, timestamp} whenever the monitored bus
// changes, and exposes the log through a valid/ready drain port.
module leds_trace
  import leds_trace_pkg::*;
#(
  parameter int WIDTH      = LT_WIDTH,
  parameter int DEPTH      = LT_DEPTH,
  parameter int TS_WIDTH   = LT_TS_WIDTH,
  parameter int DROP_WIDTH = LT_DROP_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [WIDTH-1:0]         LEDS,
  input  logic                     EN,
  input  logic                     CLEAR,
  output logic                     RD_VALID,
  input  logic                     RD_READY,
  output logic [WIDTH-1:0]         RD_LEDS,
  output logic [TS_WIDTH-1:0]      RD_TS,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic [DROP_WIDTH-1:0]    DROP_CNT
);

  typedef struct packed {
    logic [WIDTH-1:0]    leds;
    logic [TS_WIDTH-1:0] ts;
  } rec_t;

  rec_t                wr_rec;
  rec_t                rd_rec;
  logic [WIDTH-1:0]    prev;
  logic [TS_WIDTH-1:0] ts;
  logic                change;
  logic                full;
  logic                empty;
  logic                drop;

  assign change   = EN && (LEDS != prev);
  assign wr_rec   = '{leds: LEDS, ts: ts};
  // Discard only when full and nothing leaves this cycle; CLEAR suppresses it.
  assign drop     = change && full && !RD_READY && !CLEAR;
  assign RD_VALID = !empty;
  assign RD_LEDS  = rd_rec.leds;
  assign RD_TS    = rd_rec.ts;

  // Previous sample tracks the bus unconditionally, even while disabled or clearing.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) prev <= '0;
    else       prev <= LEDS;
  end

  // Free-running timestamp, wrapping naturally at its width.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      ts <= '0;
    else if (CLEAR) ts <= '0;
    else            ts <= ts + 1'b1;
  end

  // Sticky overflow flag and saturating count of discarded records.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else if (CLEAR) begin
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
      if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (WIDTH + TS_WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (CLEAR),
    .push    (change),
    .pop     (RD_READY),
    .wr_data (wr_rec),
    .rd_data (rd_rec),
    .full    (full),
    .empty   (empty),
    .count   (COUNT)
  );

endmodule

// File: tb/tb_leds_trace.sv
module tb_leds_trace;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  leds = '0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [5:0]  rd_leds;
  logic [15:0] rd_ts;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_err    = 0;

  leds_trace dut (
    .CLK      (clk),
    .RESET    (rst),
    .LEDS     (leds),
    .EN       (en),
    .CLEAR    (clear),
    .RD_VALID (rd_valid),
    .RD_READY (rd_ready),
    .RD_LEDS  (rd_leds),
    .RD_TS    (rd_ts),
    .COUNT    (count),
    .OVERFLOW (overflow),
    .DROP_CNT (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a queue of logged records plus the trace bookkeeping.
  typedef struct {
    logic [5:0]  leds;
    logic [15:0] ts;
  } rec_t;

  rec_t        q[$];
  logic [15:0] m_ts;
  logic [5:0]  m_prev;
  logic        m_ovf;
  logic [7:0]  m_drop;

  typedef struct packed {
    logic [5:0]  leds;
    logic        en;
    logic        ready;
    logic        e_valid;
    logic [4:0]  e_count;
    logic [5:0]  e_leds;
    logic [15:0] e_ts;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts   = '0;
    m_prev = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
  endtask

  task automatic model_edge();
    rec_t r;
    bit   pop;
    bit   chg;
    if (clear) begin
      q.delete();
      m_ts   = '0;
      m_ovf  = 1'b0;
      m_drop = '0;
    end else begin
      pop = rd_ready && (q.size() > 0);
      chg = en && (leds != m_prev);
      if (pop) r = q.pop_front();
      if (chg) begin
        if (q.size() < DEPTH) begin
          r.leds = leds;
          r.ts   = m_ts;
          q.push_back(r);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hff) m_drop = m_drop + 8'd1;
        end
      end
      m_ts = m_ts + 16'd1;
    end
    m_prev = leds;
  endtask

  task automatic check_model();
    check("valid", rd_valid, (q.size() != 0));
    check("count", count, q.size());
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    if (q.size() != 0) begin
      check("head_leds", rd_leds, q[0].leds);
      check("head_ts", rd_ts, q[0].ts);
    end
  endtask

  task automatic step(input logic [5:0] l, input logic e, input logic c, input logic r);
    leds     = l;
    en       = e;
    clear    = c;
    rd_ready = r;
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Asserts reset away from any edge and checks outputs before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    leds = '0; en = 1'b1; clear = 1'b0; rd_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_leds", rd_leds, 0);
    check("rst_ts", rd_ts, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Directed table: ts equals row index because the first edge after release samples ts=0.
    for (int i = 0; i < 10; i++) tbl[i] = '{6'd0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 16'd0};
    tbl[10] = '{6'h05, 1'b1, 1'b0, 1'b1, 5'd1, 6'h05, 16'd10};
    tbl[11] = '{6'h05, 1'b1, 1'b1, 1'b0, 5'd0, 6'h00, 16'd0};
    tbl[12] = '{6'h05, 1'b1, 1'b0, 1'b0, 5'd0, 6'h00, 16'd0};
    tbl[13] = '{6'h2a, 1'b1, 1'b1, 1'b1, 5'd1, 6'h2a, 16'd13};
    tbl[14] = '{6'h2a, 1'b1, 1'b0, 1'b1, 5'd1, 6'h2a, 16'd13};
    tbl[15] = '{6'h03, 1'b0, 1'b0, 1'b1, 5'd1, 6'h2a, 16'd13};
    tbl[16] = '{6'h03, 1'b1, 1'b0, 1'b1, 5'd1, 6'h2a, 16'd13};
    tbl[17] = '{6'h03, 1'b1, 1'b1, 1'b0, 5'd0, 6'h00, 16'd0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].leds, tbl[i].en, 1'b0, tbl[i].ready);
      check($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_leds", i), rd_leds, tbl[i].e_leds);
        check($sformatf("tbl%0d_ts", i), rd_ts, tbl[i].e_ts);
      end
    end

    // Idle bus after reset never logs.
    do_reset();
    for (int i = 0; i < 100; i++) step(6'd0, 1'b1, 1'b0, 1'b0);
    check("idle_count", count, 0);
    check("idle_ovf", overflow, 0);

    // Overflow: 20 changes into a 16-deep FIFO, then full push with pop, then drain.
    do_reset();
    for (int i = 0; i < 20; i++) step(6'(i + 1), 1'b1, 1'b0, 1'b0);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_cnt, 4);
    step(6'd21, 1'b1, 1'b0, 1'b1);
    check("fullpop_count", count, 16);
    check("fullpop_drop", drop_cnt, 4);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d_leds", k), rd_leds, (k < 15) ? (k + 2) : 21);
      check($sformatf("drain%0d_ts", k), rd_ts, (k < 15) ? (k + 1) : 20);
      step(6'd21, 1'b1, 1'b0, 1'b1);
    end
    check("drain_empty", count, 0);

    // Drop counter saturates.
    do_reset();
    for (int i = 0; i < 276; i++) step(i[0] ? 6'h3f : 6'h02, 1'b1, 1'b0, 1'b0);
    check("sat_drop", drop_cnt, 8'hff);
    check("sat_ovf", overflow, 1);

    // Disabled toggles are never logged, and re-enable does not log stale history.
    do_reset();
    for (int i = 0; i < 5; i++) step(i[0] ? 6'h00 : 6'h07, 1'b0, 1'b0, 1'b0);
    step(6'h07, 1'b1, 1'b0, 1'b0);
    step(6'h07, 1'b1, 1'b0, 1'b0);
    check("en_none", count, 0);
    step(6'h09, 1'b1, 1'b0, 1'b0);
    check("en_one_count", count, 1);
    check("en_one_leds", rd_leds, 6'h09);

    // CLEAR with 3 records and overflow set, together with a change.
    do_reset();
    for (int i = 0; i < 17; i++) step(6'(i + 1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step(6'd17, 1'b1, 1'b0, 1'b1);
    check("pre_clr_count", count, 3);
    check("pre_clr_ovf", overflow, 1);
    step(6'd30, 1'b1, 1'b1, 1'b0);
    check("clr_count", count, 0);
    check("clr_ovf", overflow, 0);
    check("clr_drop", drop_cnt, 0);
    check("clr_valid", rd_valid, 0);
    step(6'd31, 1'b1, 1'b0, 1'b0);
    check("post_clr_count", count, 1);
    check("post_clr_ts", rd_ts, 0);
    check("post_clr_leds", rd_leds, 6'd31);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) step(6'(i + 40), 1'b1, 1'b0, 1'b0);
    step(6'd42, 1'b1, 1'b0, 1'b1);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] l;
      l = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      step(l, ($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
